// File: rtl/sdram_line_reader.sv
// sdram_line_reader
//   Avalon-MM read master that fetches a run of consecutive 16-bit words
//   from SDRAM with pipelined reads. The words are buffered in an internal
//   FIFO and presented on a valid/ready stream. Reads in flight are
//   credit-limited against free FIFO space, so returning data always fits.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, abort        command pulse (IDLE only) / cancel level
//   base_addr           first word address, latched on start
//   word_count          number of words, latched on start
//   busy, done          transfer in progress / one-cycle completion pulse
//   m0_*                Avalon-MM read master towards the SDRAM bridge
//   out_data/valid      stream output (FIFO head)
//   out_ready           stream back-pressure
module sdram_line_reader #(
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [25:0] base_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [25:0] m0_address,
    output logic        m0_read,
    output logic        m0_write,
    output logic [15:0] m0_writedata,
    output logic        m0_chipselect,
    output logic [1:0]  m0_byteenable,
    input  logic        m0_waitrequest,
    input  logic        m0_readdatavalid,
    input  logic [15:0] m0_readdata,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam int          UW    = $clog2(FIFO_DEPTH + 1);
    localparam int          PW    = $clog2(MAX_PENDING + 1);
    localparam int unsigned DEPTH = FIFO_DEPTH;
    localparam int unsigned MAXP  = MAX_PENDING;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINISH,
        S_ABORT
    } state_t;

    state_t          state;
    logic [25:0]     addr;
    logic [15:0]     count;
    logic [15:0]     issued;
    logic [15:0]     received;
    logic [PW-1:0]   pending;
    logic            stall_q;

    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [UW-1:0]   fifo_used;
    logic [UW-1:0]   used_next;

    logic            can_issue;
    logic            stalled;
    logic            accept;
    logic            ret;
    logic            go_abort;
    logic            push;
    logic            pop;

    // Credit rule: words already buffered plus reads in flight never exceed
    // the FIFO capacity.
    assign can_issue = (state == S_RUN) && (issued < count) &&
                       (32'(pending) < MAXP) &&
                       ((32'(fifo_used) + 32'(pending)) < DEPTH);

    // A request already presented during a stall is held even if abort
    // rises; abort only suppresses fresh requests.
    assign m0_read   = can_issue && (!abort || stall_q);
    assign stalled   = m0_read && m0_waitrequest;
    assign accept    = m0_read && !m0_waitrequest;
    assign ret       = m0_readdatavalid && (pending != '0);
    assign go_abort  = abort && (((state == S_RUN) && !stalled) || (state == S_DRAIN));

    assign push      = ret && ((state == S_RUN) || (state == S_DRAIN)) && !go_abort;
    assign out_valid = (fifo_used != '0) && (state != S_ABORT);
    assign pop       = out_valid && out_ready;
    assign used_next = fifo_used + UW'(push) - UW'(pop);

    assign m0_address    = addr;
    assign m0_write      = 1'b0;
    assign m0_writedata  = '0;
    assign m0_chipselect = m0_read;
    assign m0_byteenable = 2'b11;
    assign out_data      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            addr     <= '0;
            count    <= '0;
            issued   <= '0;
            received <= '0;
            pending  <= '0;
            stall_q  <= 1'b0;
        end else begin
            done    <= 1'b0;
            stall_q <= stalled;
            if (accept) begin
                issued <= issued + 16'd1;
                addr   <= addr + 26'd1;
            end
            if (accept && !ret)
                pending <= pending + PW'(1);
            else if (!accept && ret)
                pending <= pending - PW'(1);
            if (push)
                received <= received + 16'd1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr     <= base_addr;
                        count    <= word_count;
                        issued   <= '0;
                        received <= '0;
                        busy     <= 1'b1;
                        if (word_count == '0) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (go_abort)
                        state <= S_ABORT;
                    else if (issued == count)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (go_abort) begin
                        state <= S_ABORT;
                    end else if ((received == count) && (used_next == '0)) begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_ABORT: begin
                    if (pending == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else if (go_abort) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_used <= used_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= m0_readdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (fifo_used == UW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sdram_line_reader.sv
// tb_sdram_line_reader
//   Randomized bench for sdram_line_reader. A behavioural Avalon slave
//   returns in-order data derived from the address; a reference model
//   tracks the expected address sequence, stream contents, credit limits,
//   done/busy timing and abort/reset behaviour.
module tb_sdram_line_reader;

    localparam int DEPTH = 16;
    localparam int MAXP  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [25:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [25:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [15:0] m0_writedata;
    logic        m0_chipselect;
    logic [1:0]  m0_byteenable;
    logic        m0_waitrequest;
    logic        m0_readdatavalid;
    logic [15:0] m0_readdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    sdram_line_reader #(.FIFO_DEPTH(DEPTH), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_chipselect(m0_chipselect),
        .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
        .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs
    int wait_pct, lat_min, lat_max, ready_pct;
    bit ready_force, ready_val, abort_drv, spam;
    int stall_idx = -1, stall_left = 0, stall_seen = 0;
    bit start_pend;
    logic [25:0] pend_base;
    int pend_cnt;

    // reference model
    int cyc = 0;
    bit in_xfer, aborting, chk_busy, start_now, ret_now, prev_stall;
    logic [25:0] prev_addr, xbase;
    int xcount, n_acc, n_ret, n_pop, done_due, start_cyc;
    int first_acc, last_acc, first_pop;

    // behavioural slave
    logic [25:0] sq_addr[$];
    int          sq_due[$];

    function automatic logic [15:0] mem_word(input logic [25:0] a);
        return a[15:0] ^ {a[25:16], a[5:0]} ^ 16'h5AC3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic observe();
        int due;
        if (start_now) begin
            in_xfer = 1; xbase = pend_base; xcount = pend_cnt; start_cyc = cyc;
            n_acc = 0; n_ret = 0; n_pop = 0; first_acc = 0; last_acc = 0; first_pop = 0;
            done_due = (pend_cnt == 0) ? cyc + 1 : 0;
        end
        if (prev_stall) begin
            check("stall_hold_read", m0_read, 1);
            check("stall_hold_addr", m0_address, prev_addr);
        end
        prev_stall = m0_read && m0_waitrequest;
        prev_addr  = m0_address;
        if (m0_read && m0_waitrequest && n_acc == stall_idx && stall_left > 0) begin
            stall_seen++; stall_left--;
        end
        if (!in_xfer || aborting)
            check("no_read_outside_run", m0_read && !m0_waitrequest, 0);
        else if (m0_read && !m0_waitrequest) begin
            check("rd_addr", m0_address, 26'(xbase + 26'(n_acc)));
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
            check("pending_cap", (n_acc - n_ret) <= MAXP, 1);
            check("fifo_credit", (n_acc - n_pop) <= DEPTH, 1);
            due = cyc + $urandom_range(lat_max, lat_min);
            if (sq_due.size() > 0 && due <= sq_due[$]) due = sq_due[$] + 1;
            sq_addr.push_back(m0_address);
            sq_due.push_back(due);
        end
        if (ret_now) n_ret++;
        if (!in_xfer) begin
            check("idle_out_valid", out_valid, 0);
            check("idle_busy", busy, 0);
        end else if (!aborting) begin
            if (out_valid && out_ready) begin
                check("out_data", out_data, mem_word(26'(xbase + 26'(n_pop))));
                if (n_pop == 0) first_pop = cyc;
                n_pop++;
                if (n_pop == xcount) done_due = cyc + 1;
            end
            check("done", done, cyc == done_due);
            if (chk_busy)
                check("busy", busy, (cyc > start_cyc) && (done_due == 0 || cyc <= done_due));
        end else begin
            check("abort_no_done", done, 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        start_now = 0;
        if (start_pend) begin
            start = 1; base_addr = pend_base; word_count = 16'(pend_cnt);
            start_now = 1; start_pend = 0;
        end else if (spam && in_xfer && (done_due == 0 || cyc <= done_due)) begin
            start = 1'($urandom_range(1));
            base_addr = 26'($urandom);
            word_count = 16'($urandom_range(30, 1));
        end else begin
            start = 0;
        end
        abort = abort_drv;
        if (abort_drv && in_xfer) aborting = 1;
        if (sq_due.size() > 0 && sq_due[0] <= cyc) begin
            m0_readdatavalid = 1;
            m0_readdata = mem_word(sq_addr[0]);
            void'(sq_addr.pop_front());
            void'(sq_due.pop_front());
            ret_now = 1;
        end else begin
            m0_readdatavalid = 0;
            m0_readdata = 16'($urandom);
            ret_now = 0;
        end
        if (stall_left > 0 && n_acc == stall_idx) m0_waitrequest = 1;
        else m0_waitrequest = ($urandom_range(99) < wait_pct);
        out_ready = ready_force ? ready_val : ($urandom_range(99) < ready_pct);
        #1;
        observe();
    endtask

    task automatic start_xfer(input logic [25:0] b, input int n);
        pend_base = b; pend_cnt = n; start_pend = 1; chk_busy = 1;
        tick();
    endtask

    task automatic finish_xfer(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_due != 0 && cyc == done_due + 1) break;
            tick();
        end
        check("xfer_complete", (done_due != 0) && (cyc == done_due + 1), 1);
        check("words_delivered", n_pop, xcount);
        in_xfer = 0; stall_left = 0; stall_idx = -1; spam = 0;
    endtask

    task automatic randomize_knobs();
        wait_pct = $urandom_range(40); lat_min = 1; lat_max = $urandom_range(6, 1);
        ready_pct = $urandom_range(100, 30); ready_force = 0;
    endtask

    initial begin
        rst = 0; start = 0; abort = 0; base_addr = '0; word_count = '0;
        m0_waitrequest = 0; m0_readdatavalid = 0; m0_readdata = '0; out_ready = 0;
        wait_pct = 0; lat_min = 1; lat_max = 1; ready_pct = 100;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", m0_read, 0);
        check("rst_addr", m0_address, 0);
        check("rst_out_valid", out_valid, 0);
        check("const_write", {m0_write, m0_writedata, m0_byteenable}, 19'h3);
        @(negedge clk); rst = 1;

        // back-to-back basic transfer, 1-cycle slave, always ready
        ready_force = 1; ready_val = 1;
        start_xfer(26'h0000100, 4);
        finish_xfer(100);
        check("b2b_issue", last_acc - first_acc, 3);
        check("min_latency", first_pop - first_acc, 2);

        // back-pressure: FIFO fills to capacity, then drains
        wait_pct = 20; lat_min = 1; lat_max = 4; ready_force = 1; ready_val = 0;
        start_xfer(26'(32'h0123456), 40);
        repeat (60) tick();
        check("fill_limit", n_acc, DEPTH);
        check("fill_read_low", m0_read, 0);
        ready_force = 0; ready_pct = 70;
        finish_xfer(2000);

        // 5-cycle stall on the second read
        wait_pct = 0; lat_min = 2; lat_max = 2; ready_force = 1; ready_val = 1;
        stall_idx = 1; stall_left = 5; stall_seen = 0;
        start_xfer(26'h0200000, 6);
        finish_xfer(200);
        check("stall_cycles", stall_seen, 5);

        // address wrap
        randomize_knobs();
        start_xfer(26'h3FFFFFE, 3);
        finish_xfer(300);

        // abort with three reads in flight
        wait_pct = 0; lat_min = 3; lat_max = 3; ready_force = 1; ready_val = 0;
        start_xfer(26'h0001000, 20);
        chk_busy = 0;
        for (int i = 0; i < 100 && n_acc < 6; i++) tick();
        check("abort_setup", n_acc, 6);
        check("abort_pending", n_acc - n_ret, 3);
        abort_drv = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 1) check("abort_out_valid", out_valid, 0);
            if (!busy) break;
        end
        check("abort_idle", busy, 0);
        check("abort_drained", sq_due.size(), 0);
        check("abort_reads", n_acc, 6);
        in_xfer = 0; aborting = 0;
        repeat (3) tick();              // abort held while idle: ignored
        abort_drv = 0;

        // zero-length transfer, then randomized transfers with start spam
        randomize_knobs();
        start_xfer(26'h0000040, 0);
        finish_xfer(20);
        for (int t = 0; t < 6; t++) begin
            randomize_knobs();
            start_xfer(26'($urandom), $urandom_range(50, 1));
            spam = 1;
            finish_xfer(3000);
            repeat ($urandom_range(3)) tick();
        end

        // reset in the middle of a transfer
        wait_pct = 0; lat_min = 4; lat_max = 4; ready_force = 1; ready_val = 0;
        start_xfer(26'h0ABCDEF, 30);
        for (int i = 0; i < 100 && n_acc < 5; i++) tick();
        #1 rst = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_read", m0_read, 0);
        check("midrst_addr", m0_address, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_done", done, 0);
        in_xfer = 0; prev_stall = 0;
        tick(); tick();
        rst = 1;
        for (int i = 0; i < 40 && sq_due.size() > 0; i++) tick();
        check("late_returns_drained", sq_due.size(), 0);
        tick();
        randomize_knobs();
        start_xfer(26'($urandom), 12);
        finish_xfer(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_line_reader.md
Name: sdram_line_reader

Overview:
- Avalon-MM read master that sits directly upstream of the SDRAM pass-through bridge and drives its slave side.
- On a start command it fetches a run of consecutive 16-bit words from SDRAM using pipelined reads.
- It buffers the words in an internal FIFO and presents them on a valid/ready stream for a downstream consumer such as a display or line processor.
- Outstanding reads are credit-limited, so returning data can never overflow the FIFO.

Parameters:
- FIFO_DEPTH, 16, FIFO entries (power of two, 4..256).
- MAX_PENDING, 8, maximum reads in flight (1..FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- abort  in  1  cancel the current transfer; level, sampled every cycle.
- base_addr  in  26  first word address, latched on start.
- word_count  in  16  number of words to fetch, latched on start.
- busy  out  1  high from the accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the last word is accepted on the stream.
- m0_address  out  26  read word address.
- m0_read  out  1  read request.
- m0_write  out  1  constant 0.
- m0_writedata  out  16  constant 0.
- m0_chipselect  out  1  equals m0_read.
- m0_byteenable  out  2  constant 2'b11.
- m0_waitrequest  in  1  slave stall.
- m0_readdatavalid  in  1  read data valid.
- m0_readdata  in  16  read data.
- out_data  out  16  stream data (FIFO head).
- out_valid  out  1  FIFO not empty and not flushing.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; FIFO empty; all counters 0. Outputs: busy=0, done=0, m0_read=0, m0_address=0, out_valid=0.
- States:
  - IDLE -> RUN on start when word_count!=0. Latch address and count; busy=1 on the next cycle.
  - IDLE -> FINISH on start when word_count==0. No reads issued; done pulses the cycle after start; busy is high for that one cycle only.
  - RUN: issue reads. Go to DRAIN when issued==count.
  - DRAIN: no new reads. Wait until received==count and the FIFO is empty, then go to FINISH.
  - FINISH: done=1 for one cycle; busy=0 next cycle; return to IDLE.
  - ABORT: entered from RUN or DRAIN when abort=1. Stop issuing. Discard all returning data. FIFO is flushed and out_valid=0. Wait until pending==0, then go to IDLE with no done pulse.
- Read issue:
  - m0_read=1 when in RUN, issued<count, pending<MAX_PENDING, and fifo_used+pending<FIFO_DEPTH.
  - While m0_waitrequest=1, m0_read and m0_address are held stable. Requests are never withdrawn mid-stall, even if abort asserts; abort takes effect after the stalled request is accepted.
  - A request is accepted when m0_read & !m0_waitrequest. On acceptance: issued+1, address+1 modulo 2^26 (wraps 0x3FFFFFF -> 0x0000000), pending+1.
- Read return:
  - Each m0_readdatavalid cycle decrements pending and writes m0_readdata into the FIFO, unless aborting.
  - Simultaneous accept and return leave pending unchanged.
  - Returns arrive in order; the credit rule guarantees no FIFO overflow. Overflow is an assertion failure.
- Stream:
  - out_data is the FIFO head, combinational from FIFO storage.
  - A FIFO write and read in the same cycle keeps fifo_used constant.
  - Minimum latency: slave returns data one cycle after acceptance -> out_valid high on the following cycle (FIFO write registered).
- Completion: done pulses exactly once per non-aborted start, after the word_count-th stream handshake.
- start while busy is ignored.
- abort while in IDLE or FINISH is ignored.
- Asserting rst mid-transfer returns to reset state immediately. Late m0_readdatavalid after reset is ignored because pending=0.

Test Plan:
- start, base=0x0000100, count=4, slave 1-cycle latency, no wait, out_ready=1 -> addresses 0x100..0x103 issued back-to-back; 4 words out in order; done one cycle after the 4th handshake; busy falls the next cycle.
- count=40, out_ready=0 -> at most FIFO_DEPTH=16 words fetched, never more than 8 pending, m0_read low once full. Release out_ready -> all 40 words delivered in order, then done.
- m0_waitrequest held high 5 cycles on the 2nd read -> m0_address stays at base+1 for all 5 cycles; no duplicate or skipped addresses.
- base=0x3FFFFFE, count=3 -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0000000.
- abort after 6 of 20 reads issued, 3 returns still pending -> no further reads; 3 late returns discarded; out_valid=0; back to IDLE with busy=0 and no done. A following start works normally.
- start with count=0 -> no m0_read; done pulses 1 cycle later. A start while busy changes nothing. rst=0 mid-transfer -> all outputs at reset values in the same cycle.
